// File: rtl/riscv_ifetch_if.sv
// Instruction-memory read bus between the prefetch stage (master)
// and instruction memory (slave): one outstanding request, held until ack.
interface riscv_ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/riscv_ifetch.sv
// Instruction prefetch stage: fetches sequential words into a small
// {pc, word} queue, presents the head word when it matches the core's
// address, and flushes/refetches whenever the core leaves the stream.
module riscv_ifetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    pc_in,
  input  logic           instr_take,
  output logic [31:0]    instr,
  output logic           instr_valid,
  output logic           redirect,
  riscv_ifetch_if.master imem
);

  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0]   NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_pop;
  logic [CW-1:0] w_count_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_next;
  logic [31:0]   r_req_addr;
  logic [31:0]   w_req_addr_next;
  logic          r_imem_req;

  logic [31:0]   r_q_pc   [DEPTH];
  logic [31:0]   r_q_word [DEPTH];

  logic          w_has;
  logic          w_ack;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_expected;

  // Head match, redirect detection and queue occupancy arithmetic
  always_comb begin
    w_has        = (r_count != '0);
    w_head_pc    = r_q_pc[r_head];
    w_expected   = w_has ? w_head_pc : r_fetch_pc;
    redirect     = (pc_in != w_expected);
    instr_valid  = w_has && (w_head_pc == pc_in);
    instr        = instr_valid ? r_q_word[r_head] : NOP;
    w_ack        = r_imem_req && imem.imem_ack;
    // A redirect never coincides with a valid head, so pops are never stale.
    w_pop        = instr_valid && instr_take;
    w_push       = (r_state == S_REQ) && w_ack && !redirect;
    w_count_pop  = r_count - {{(CW-1){1'b0}}, w_pop};
    w_count_next = w_count_pop + {{(CW-1){1'b0}}, w_push};
  end

  // Fetch FSM next state, next request address and next fetch pointer
  always_comb begin
    w_state_next    = r_state;
    w_req_addr_next = r_req_addr;
    w_fetch_pc_next = redirect ? pc_in : r_fetch_pc;
    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_state_next    = S_REQ;
          w_req_addr_next = pc_in;
        end else if (w_count_pop < FULL) begin
          w_state_next    = S_REQ;
          w_req_addr_next = r_fetch_pc;
        end
      end
      S_REQ: begin
        if (redirect) begin
          if (w_ack) begin
            w_state_next    = S_REQ;
            w_req_addr_next = pc_in;
          end else begin
            // The bus handshake cannot be withdrawn; wait out the stale ack.
            w_state_next = S_DROP;
          end
        end else if (w_ack) begin
          w_fetch_pc_next = r_req_addr + 32'd1;
          if (w_count_next < FULL) begin
            w_state_next    = S_REQ;
            w_req_addr_next = r_req_addr + 32'd1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (w_ack) begin
          w_state_next    = S_REQ;
          w_req_addr_next = redirect ? pc_in : r_fetch_pc;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Control registers: FSM state, pointers, occupancy, fetch/request addresses
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_imem_req <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_imem_req <= (w_state_next != S_IDLE);
      r_fetch_pc <= w_fetch_pc_next;
      r_req_addr <= w_req_addr_next;
      if (redirect) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        r_count <= w_count_next;
      end
    end
  end

  // Queue storage write at the tail on each accepted memory response
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_q_pc[r_tail]   <= r_req_addr;
      r_q_word[r_tail] <= imem.imem_rdata;
    end
  end

  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = r_req_addr;

endmodule

// File: tb/tb_riscv_ifetch.sv
// Bench for riscv_ifetch: directed scenarios followed by randomized core
// and memory behaviour, all checked against a queue-based reference model.
module tb_riscv_ifetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in;
  logic        instr_take;
  logic [31:0] instr;
  logic        instr_valid;
  logic        redirect;

  riscv_ifetch_if imem_bus ();

  riscv_ifetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .instr_take  (instr_take),
    .instr       (instr),
    .instr_valid (instr_valid),
    .redirect    (redirect),
    .imem        (imem_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: FIFO of fetched {pc, word}, next sequential pc, and
  // the single outstanding request (address, and whether it is stale).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_paddr;
  bit          m_pend;
  bit          m_drop;

  // Memory responder state
  bit          mem_active;
  int          mem_left;
  logic [31:0] mem_addr;
  int          lat_lo = 0;
  int          lat_hi = 0;
  bit          scramble = 1'b0;

  // Core behaviour and observed outputs of the latest cycle
  logic [31:0] core_pc;
  bit          take_v;
  logic [31:0] o_instr;
  logic [31:0] o_addr;
  logic        o_valid;
  logic        o_redir;
  logic        o_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return scramble ? (a ^ 32'h3C3C_5A5A) : a;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_fetch    = RESET_PC;
    m_paddr    = RESET_PC;
    m_pend     = 1'b0;
    m_drop     = 1'b0;
    mem_active = 1'b0;
  endtask

  // One clock cycle, entered at a falling edge: drive, predict, compare, advance
  task automatic step_at_negedge();
    logic        e_valid;
    logic        e_redir;
    logic [31:0] e_instr;
    logic        ack_v;
    logic [31:0] rd_v;
    ent_t        e;
    pc_in      = core_pc;
    instr_take = take_v;
    if (imem_bus.imem_req === 1'b1) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        mem_left   = $urandom_range(lat_hi, lat_lo);
        mem_addr   = imem_bus.imem_addr;
      end else begin
        chk("addr_hold", imem_bus.imem_addr, mem_addr);
      end
      imem_bus.imem_ack   = (mem_left == 0);
      imem_bus.imem_rdata = imem_bus.imem_ack ? mem_word(imem_bus.imem_addr) : $urandom();
    end else begin
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = $urandom();
    end
    #1;
    e_valid = 1'b0;
    e_instr = NOP;
    e_redir = (pc_in != m_fetch);
    if (m_q.size() > 0) begin
      e_valid = (m_q[0].pc == pc_in);
      e_redir = (m_q[0].pc != pc_in);
      if (e_valid) e_instr = m_q[0].w;
    end
    o_instr = instr;
    o_valid = instr_valid;
    o_redir = redirect;
    o_req   = imem_bus.imem_req;
    o_addr  = imem_bus.imem_addr;
    chk("instr_valid", {31'b0, o_valid}, {31'b0, e_valid});
    chk("instr", o_instr, e_instr);
    chk("redirect", {31'b0, o_redir}, {31'b0, e_redir});
    chk("imem_req", {31'b0, o_req}, {31'b0, m_pend});
    if (m_pend) chk("imem_addr", o_addr, m_paddr);
    ack_v = imem_bus.imem_ack;
    rd_v  = imem_bus.imem_rdata;
    @(posedge clk);
    if (e_redir) begin
      m_q.delete();
      m_fetch = pc_in;
      if (m_pend && !ack_v) begin
        m_drop = 1'b1;
      end else begin
        m_pend  = 1'b1;
        m_paddr = pc_in;
        m_drop  = 1'b0;
      end
    end else begin
      if (e_valid && take_v) void'(m_q.pop_front());
      if (m_pend && ack_v) begin
        if (m_drop) begin
          m_drop  = 1'b0;
          m_paddr = m_fetch;
        end else begin
          e.pc = m_paddr;
          e.w  = rd_v;
          m_q.push_back(e);
          m_fetch = m_paddr + 32'd1;
          if (m_q.size() < DEPTH) m_paddr = m_fetch;
          else m_pend = 1'b0;
        end
      end else if (!m_pend && m_q.size() < DEPTH) begin
        m_pend  = 1'b1;
        m_paddr = m_fetch;
        m_drop  = 1'b0;
      end
    end
    if (ack_v) mem_active = 1'b0;
    else if (mem_active) mem_left--;
    if (e_valid && take_v) core_pc = core_pc + 32'd1;
  endtask

  task automatic step();
    @(negedge clk);
    step_at_negedge();
  endtask

  // Hold reset for n edges, check reset outputs, then run the first free cycle
  task automatic do_reset(input int n);
    @(negedge clk);
    rst                 = 1'b0;
    imem_bus.imem_ack   = 1'b0;
    pc_in               = core_pc;
    instr_take          = 1'b0;
    take_v              = 1'b0;
    repeat (n) @(posedge clk);
    model_reset();
    @(negedge clk);
    chk("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_addr", imem_bus.imem_addr, RESET_PC);
    chk("rst_instr", instr, NOP);
    chk("rst_redirect", {31'b0, redirect}, {31'b0, core_pc != RESET_PC});
    rst = 1'b1;
    step_at_negedge();
  endtask

  initial begin
    logic [31:0] base;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    core_pc             = RESET_PC;
    pc_in               = RESET_PC;
    instr_take          = 1'b0;
    take_v              = 1'b0;
    model_reset();

    // Reset hold, then zero-wait fill with the core stalled
    do_reset(3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fill_req", {31'b0, o_req}, 32'd1);
      chk("fill_addr", o_addr, RESET_PC + 32'(i));
    end
    step();
    chk("full_idle", {31'b0, o_req}, 32'd0);
    chk("full_head", o_instr, RESET_PC);

    // Core consumes one word per cycle with no bubble
    take_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("stream_valid", {31'b0, o_valid}, 32'd1);
      chk("stream_instr", o_instr, RESET_PC + 32'(i));
    end

    // Fill 80000010..13 then jump to 80000040
    take_v  = 1'b0;
    core_pc = 32'h8000_0010;
    step();
    repeat (5) step();
    chk("q10_head", o_instr, 32'h8000_0010);
    chk("q10_idle", {31'b0, o_req}, 32'd0);
    core_pc = 32'h8000_0040;
    step();
    chk("jmp_redirect", {31'b0, o_redir}, 32'd1);
    step();
    chk("jmp_redirect_once", {31'b0, o_redir}, 32'd0);
    chk("jmp_req_addr", o_addr, 32'h8000_0040);
    step();
    chk("jmp_valid", {31'b0, o_valid}, 32'd1);
    chk("jmp_instr", o_instr, 32'h8000_0040);
    repeat (4) step();

    // 3-cycle latency: redirect to 0x100 while 0x20 is outstanding
    lat_lo  = 3;
    lat_hi  = 3;
    core_pc = 32'h0000_0020;
    step();
    step();
    chk("pend_addr", o_addr, 32'h0000_0020);
    core_pc = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drop_req", {31'b0, o_req}, 32'd1);
      chk("drop_addr_hold", o_addr, 32'h0000_0020);
    end
    step();
    chk("after_drop_addr", o_addr, 32'h0000_0100);
    repeat (3) step();
    step();
    chk("lat_valid", {31'b0, o_valid}, 32'd1);
    chk("lat_instr", o_instr, 32'h0000_0100);

    // Full queue, pop then refill; new tail follows the last pc
    lat_lo = 0;
    lat_hi = 0;
    repeat (10) step();
    chk("full2_idle", {31'b0, o_req}, 32'd0);
    take_v = 1'b1;
    step();
    take_v = 1'b0;
    repeat (2) step();
    take_v = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("tail_instr", o_instr, 32'h0000_0100 + 32'(i));
    end

    // Address wrap past 32'hFFFFFFFF
    base    = 32'hFFFF_FFFE;
    core_pc = base;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 4) chk("wrap_addr", o_addr, base + 32'(k));
      if (k >= 1) chk("wrap_instr", o_instr, base + 32'(k - 1));
    end

    // Randomized core and memory behaviour
    scramble = 1'b1;
    lat_lo   = 0;
    lat_hi   = 3;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset(2);
      take_v = ($urandom_range(3, 0) != 0);
      if ($urandom_range(24, 0) == 0) begin
        case ($urandom_range(3, 0))
          0: core_pc = $urandom();
          1: core_pc = 32'hFFFF_FFFC + 32'($urandom_range(3, 0));
          2: core_pc = core_pc - 32'd2;
          default: core_pc = core_pc + 32'd3;
        endcase
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
